// File: rtl/window_conv.sv
// ---------------------------------------------------------------------------
// window_conv
//
// Purpose:
//   Convolution stage that sits downstream of a SIZE x SIZE line/shift tap
//   window. Every clock it produces one filtered pixel. Each channel is a
//   weighted sum of all N = SIZE*SIZE window pixels using programmable signed
//   coefficients. The sum is then rounded, shifted right by SHIFT and
//   saturated to the channel range. Coefficients are written into a shadow
//   bank at any time. The active bank copies the shadow bank only on a rising
//   edge of invs, so a frame is always filtered with one consistent set.
//
// Ports:
//   clock       system clock
//   rst_n       asynchronous active-low reset
//   invs        window vertical sync from the tap stage
//   inde        window data enable from the tap stage
//   indata      N packed pixels; tap t = row*SIZE+col at [t*DSIZE +: DSIZE]
//   coef_we     shadow coefficient write strobe
//   coef_addr   tap index of the write (indices >= N are ignored)
//   coef_wdata  signed coefficient value
//   outvs       invs delayed by the pipeline latency
//   outde       inde delayed by the pipeline latency
//   outdata     filtered pixel, zero whenever outde is low
//
// Latency is D + 2 clocks, where D = ceil(log2(N)): one multiply stage, D
// adder-tree levels and one round/saturate stage.
// ---------------------------------------------------------------------------
module window_conv #(
    parameter int SIZE     = 3,
    parameter int DSIZE    = 24,
    parameter int CHANNELS = 3,
    parameter int COEF_W   = 8,
    parameter int SHIFT    = 4
) (
    input  logic                      clock,
    input  logic                      rst_n,
    input  logic                      invs,
    input  logic                      inde,
    input  logic [DSIZE*SIZE*SIZE-1:0] indata,
    input  logic                      coef_we,
    input  logic [7:0]                coef_addr,
    input  logic [COEF_W-1:0]         coef_wdata,
    output logic                      outvs,
    output logic                      outde,
    output logic [DSIZE-1:0]          outdata
);

    localparam int N        = SIZE * SIZE;
    localparam int CW       = DSIZE / CHANNELS;
    localparam int PW       = CW + COEF_W + 1;
    localparam int D        = $clog2(N);
    localparam int SW       = PW + D;
    localparam int L        = D + 2;
    localparam int CENTRE   = (N - 1) / 2;
    localparam int ROUND_I  = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;

    localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(1 << SHIFT);
    localparam logic signed [SW:0]       ROUND = (SW+1)'(ROUND_I);
    localparam logic signed [SW:0]       MAXV  = (SW+1)'((1 << CW) - 1);

    // Coefficient banks and frame-sync edge detector
    logic signed [COEF_W-1:0] shadow_q [N];
    logic signed [COEF_W-1:0] shadow_d [N];
    logic signed [COEF_W-1:0] active_q [N];
    logic signed [COEF_W-1:0] active_d [N];
    logic                     vs_dly_q;
    logic                     vs_dly_d;
    logic                     vs_rise;

    // Arithmetic pipeline: level 0 holds the products, level D holds the sum
    // in index 0. Entries beyond the live operand count of a level stay zero.
    logic signed [SW-1:0] tree_q [CHANNELS][D+1][N];
    logic signed [SW-1:0] tree_d [CHANNELS][D+1][N];

    // Round / shift / saturate stage
    logic signed [SW:0]   rounded [CHANNELS];
    logic signed [SW:0]   shifted [CHANNELS];
    logic [DSIZE-1:0]     sat_pix;
    logic [DSIZE-1:0]     outdata_q;
    logic [DSIZE-1:0]     outdata_d;

    // Sync/enable delay line matching the arithmetic latency
    logic [L-1:0]         vs_pipe_q;
    logic [L-1:0]         vs_pipe_d;
    logic [L-1:0]         de_pipe_q;
    logic [L-1:0]         de_pipe_d;

    // Shadow writes land at any time. On a rising invs the active bank takes
    // the shadow contents as they were before this cycle's write, so a write
    // that coincides with the frame start only takes effect a frame later.
    always_comb begin
        vs_dly_d = invs;
        vs_rise  = invs & ~vs_dly_q;
        for (int t = 0; t < N; t++) begin
            shadow_d[t] = shadow_q[t];
            active_d[t] = active_q[t];
            if (vs_rise) begin
                active_d[t] = shadow_q[t];
            end
            if (coef_we && (coef_addr == 8'(t))) begin
                shadow_d[t] = coef_wdata;
            end
        end
    end

    // Multiply stage and registered binary adder tree. Each level adds
    // neighbouring pairs; with an odd count the last operand passes through
    // unchanged, so the total is preserved and collapses into index 0 after
    // D levels.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            for (int l = 0; l <= D; l++) begin
                for (int i = 0; i < N; i++) begin
                    tree_d[c][l][i] = '0;
                end
            end
            for (int t = 0; t < N; t++) begin
                tree_d[c][0][t] = $signed({{(SW-CW){1'b0}}, indata[t*DSIZE + c*CW +: CW]})
                                  * SW'(active_q[t]);
            end
            for (int l = 1; l <= D; l++) begin
                for (int i = 0; i < N; i++) begin
                    if (i < N / 2) begin
                        tree_d[c][l][i] = tree_q[c][l-1][2*i] + tree_q[c][l-1][2*i+1];
                    end else if ((i == N / 2) && ((N % 2) == 1)) begin
                        tree_d[c][l][i] = tree_q[c][l-1][N-1];
                    end
                end
            end
        end
    end

    // Round half up, arithmetic shift, clamp to [0, 2^CW-1]. Data is masked
    // to zero when the matching enable is low.
    always_comb begin
        sat_pix = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            rounded[c] = (SW+1)'(tree_q[c][D][0]) + ROUND;
            shifted[c] = rounded[c] >>> SHIFT;
            if (shifted[c][SW]) begin
                sat_pix[c*CW +: CW] = '0;
            end else if (shifted[c] > MAXV) begin
                sat_pix[c*CW +: CW] = {CW{1'b1}};
            end else begin
                sat_pix[c*CW +: CW] = shifted[c][CW-1:0];
            end
        end
        outdata_d = de_pipe_q[L-2] ? sat_pix : '0;
        vs_pipe_d = {vs_pipe_q[L-2:0], invs};
        de_pipe_d = {de_pipe_q[L-2:0], inde};
    end

    // All state; reset restores identity coefficients and flushes the pipe.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            vs_dly_q  <= 1'b0;
            vs_pipe_q <= '0;
            de_pipe_q <= '0;
            outdata_q <= '0;
            for (int t = 0; t < N; t++) begin
                shadow_q[t] <= (t == CENTRE) ? UNITY : '0;
                active_q[t] <= (t == CENTRE) ? UNITY : '0;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                for (int l = 0; l <= D; l++) begin
                    for (int i = 0; i < N; i++) begin
                        tree_q[c][l][i] <= '0;
                    end
                end
            end
        end else begin
            vs_dly_q  <= vs_dly_d;
            vs_pipe_q <= vs_pipe_d;
            de_pipe_q <= de_pipe_d;
            outdata_q <= outdata_d;
            for (int t = 0; t < N; t++) begin
                shadow_q[t] <= shadow_d[t];
                active_q[t] <= active_d[t];
            end
            for (int c = 0; c < CHANNELS; c++) begin
                for (int l = 0; l <= D; l++) begin
                    for (int i = 0; i < N; i++) begin
                        tree_q[c][l][i] <= tree_d[c][l][i];
                    end
                end
            end
        end
    end

    assign outvs   = vs_pipe_q[L-1];
    assign outde   = de_pipe_q[L-1];
    assign outdata = outdata_q;

endmodule

// File: doc/window_conv.md
Name: window_conv

Overview:
- Downstream consumer of the SIZE x SIZE line/shift tap window.
- Computes one output pixel per clock: a per-channel weighted sum of all SIZE*SIZE window pixels using programmable signed coefficients, then round, shift and saturate.
- Coefficients are written into a shadow bank at any time. They are applied frame-synchronously at the rising edge of invs.
- The vs/de timing is delayed to match the arithmetic pipeline, so the output feeds the next video stage directly.

Parameters:
- SIZE, 3: window edge; N = SIZE*SIZE taps.
- DSIZE, 24: pixel width, all channels packed.
- CHANNELS, 3: channels per pixel; CW = DSIZE/CHANNELS, which must divide exactly.
- COEF_W, 8: signed two's-complement coefficient width.
- SHIFT, 4: right-shift normalisation; 1.0 = 1<<SHIFT.

Ports:
- clock  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- invs  in  1  window vertical sync, from the tap stage
- inde  in  1  window data enable, from the tap stage
- indata  in  DSIZE*N  window
  - tap t = row*SIZE+col occupies bits [t*DSIZE +: DSIZE].
  - Row 0 is the newest line.
  - Channel c of a pixel is bits [c*CW +: CW], unsigned.
- coef_we  in  1  shadow coefficient write strobe
- coef_addr  in  8  tap index t of the write
- coef_wdata  in  COEF_W  signed coefficient value
- outvs  out  1  vs delayed by L
- outde  out  1  de delayed by L
- outdata  out  DSIZE  filtered pixel, same channel packing as the input

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clock. All state is clocked on posedge clock.
- Reset values:
  - outvs, outde = 0; outdata = 0.
  - All pipeline registers = 0.
  - Shadow and active banks = identity: tap (N-1)/2 = 1<<SHIFT, all others 0.
- Coefficient write: when coef_we=1 and coef_addr < N, shadow[coef_addr] <= coef_wdata on the clock edge. If coef_addr >= N the write is ignored, with no side effect.
- Frame sync:
  - vs_d is invs registered; vs_rise = invs & ~vs_d.
  - On vs_rise, active[t] <= shadow[t] for every t.
  - If coef_we coincides with vs_rise, active receives the pre-write shadow value. The new value reaches active at the following vs_rise.
  - Active coefficients never change mid-frame.
- Pipeline, per channel, independently:
  - Stage M (1 cycle): prod[t] = pixel_c[t] (unsigned CW, zero-extended) * active[t] (signed). Width CW+COEF_W+1, signed.
  - Stage A (D = ceil(log2(N)) cycles): registered binary adder tree, one level per cycle. An odd leftover operand is passed through a register. Sum width is CW+COEF_W+1+D, signed, with no overflow possible.
  - Stage R (1 cycle):
    - If SHIFT>0, add 1<<(SHIFT-1); then apply an arithmetic right shift by SHIFT.
    - Saturate: result < 0 gives 0; result > 2^CW-1 gives 2^CW-1.
- Latency L = D + 2. For SIZE=3, L = 6.
- outvs/outde are a shift register of depth L on {invs, inde}. There are no gaps or bubbles; throughput is 1 pixel/clock.
- When the delayed de is 0, outdata is forced to 0, registered in stage R.
- indata is used as given. Zeroed taps at image borders are the upstream stage's responsibility.
- Reset mid-frame: all outputs go to 0 immediately (asynchronously). Both banks return to identity, the pipeline is flushed, and the first output after release follows the normal latency.
- Pixel data arriving with inde=0 still propagates through the arithmetic, but it is masked at the output.

Test Plan:
- Identity after reset:
  - Stimulus: window of distinct pixels, centre tap 0x123456, inde=1.
  - Required: outdata = 0x123456 exactly 6 cycles later, with outde asserted that same cycle.
- Box filter:
  - Stimulus: all 9 shadow coefs = 1, then an invs pulse, then all pixels 0x808080.
  - Required: sum 1152, +8, >>4 = 72, so outdata = 0x484848.
- Saturation:
  - Stimulus: centre coef 127, others 0, centre pixel 0xC8C8C8 (200).
  - Required: 25400 >> 4 = 1588, clamped to 0xFFFFFF.
  - Stimulus: centre coef -16, centre pixel 0x323232.
  - Required: outdata = 0x000000.
- Frame-sync update:
  - Stimulus: write centre coef = 32 mid-frame.
  - Required: output stays at identity until the next invs rise; then centre pixel 0x101010 gives 0x202020.
  - Stimulus: coef_we in the same cycle as vs_rise.
  - Required: the old value takes effect this frame; the new value takes effect next frame.
- Timing and masking:
  - Stimulus: invs pulse 3 clocks, then an inde burst of 1920 clocks.
  - Required: outvs and outde are the same lengths, delayed exactly 6 clocks; outdata = 0 whenever outde = 0. A write with coef_addr = 9 leaves all coefs unchanged.
- Reset mid-frame:
  - Stimulus: assert rst_n low during an active line.
  - Required: outvs, outde and outdata go to 0 asynchronously. After release, identity coefs are active and the first valid output appears 6 cycles after the first inde.
